spi_slave_engine: RTL
=====================

Name: spi_slave_engine

Overview:
- SPI slave (responder) engine; the counterpart of the SPI_TOP master.
- Samples the external SCK/SS/MOSI lines in the system clk domain and shifts 8-bit frames in both directions.
- Drives MISO with a tristate enable.
- Exposes a one-deep transmit buffer with a ready/load handshake, and a receive register with a sticky SPIF flag and an overrun flag.

Parameters:
- DATA_W, 8, frame width in bits.
- SYNC_STAGES, 2, synchronizer depth for the SCK, SS and MOSI inputs (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- SPE  input  1  slave enable; 0 forces IDLE and tristates MISO.
- CPOL  input  1  SCK idle level.
- CPHA  input  1  0 = sample on leading edge; 1 = sample on trailing edge.
- LSBFE  input  1  1 = LSB first; 0 = MSB first.
- SCK  input  1  serial clock from the master (asynchronous).
- SS  input  1  slave select, active-low (asynchronous).
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master.
- MISO_oe  output  1  MISO drive enable (1 = drive).
- tx_data  input  DATA_W  byte to transmit.
- tx_load  input  1  write strobe for tx_data; accepted only when tx_ready=1.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  DATA_W  last completed received byte.
- SPIF  output  1  transfer-complete flag, sticky.
- SPIF_clr  input  1  clears SPIF and rx_ovr.
- rx_ovr  output  1  overrun: a frame completed while SPIF was already 1.

Behaviour:
- Reset values: MISO=0, MISO_oe=0, tx_ready=1, rx_data=0, SPIF=0, rx_ovr=0, state=IDLE, bit counter=0. Synchronizers reset to SCK=CPOL, SS=1, MOSI=0.
- Rate requirement: SCK frequency ≤ clk/8. Edge latency from a pin edge to its internal detection is SYNC_STAGES+1 clk cycles.
- Edge detection: compare the synchronized SCK with its delayed copy.
  - Leading edge = transition away from CPOL.
  - Trailing edge = transition back to CPOL.
- MISO_oe = SPE & ~SS_sync, registered.
- State machine, IDLE:
  - On a falling SS_sync with SPE=1, go to ACTIVE and clear the bit counter.
  - Load the shift register from the tx buffer if it is full (then tx_ready=1 next cycle), else load all zeros.
  - For CPHA=0, MISO presents the first bit in the same cycle as the load.
- State machine, ACTIVE, CPHA=0:
  - Leading edge: sample MOSI into the shift register.
  - Trailing edge: shift out the next bit.
- State machine, ACTIVE, CPHA=1:
  - Leading edge: shift out the next bit (the first leading edge presents bit 0).
  - Trailing edge: sample MOSI.
- Bit order: LSBFE selects the shift direction for both TX and RX. First bit out and first bit in are bit 0 when LSBFE=1, bit DATA_W-1 when LSBFE=0.
- Frame completion, on the DATA_W-th sample:
  - If SPIF=0: rx_data <= assembled byte and SPIF <= 1.
  - If SPIF=1: rx_data is held, rx_ovr <= 1 and the byte is discarded.
  - Bit counter wraps to 0. If SS is still low, the tx buffer (or zeros) reloads into the shift register at the next shift point, giving back-to-back frames.
- tx handshake:
  - tx_load with tx_ready=1 captures tx_data; tx_ready goes 0 the next cycle.
  - tx_load with tx_ready=0 is ignored, and the buffer keeps its old value.
  - tx_load and a buffer-to-shift-register transfer in the same cycle: the transfer takes the old buffer content and the new data is captured, so tx_ready stays 0.
- SPIF_clr and a frame completion in the same cycle: completion wins. SPIF=1 with the new data, and rx_ovr is cleared.
- Abort: SS_sync rising mid-frame, or SPE dropping, returns the block to IDLE.
  - The partial frame is discarded; no SPIF and no rx_data change.
  - The counter is cleared, MISO_oe=0 and MISO=0.
  - The tx buffer content is preserved if it was not yet transferred.
- rst asserted mid-frame: every register returns to its reset value on the next clk edge.

Decomposition:
- Shared package spi_pkg holds:
  - constants DATA_W_DEFAULT=8 and SYNC_STAGES_DEFAULT=2;
  - the state enum {IDLE, ACTIVE};
  - the mode encoding {CPOL, CPHA}.
- One sub-module, spi_sync_edge: a parameterised N-stage synchronizer with rise/fall pulse outputs. It is instantiated for SCK and SS; MOSI uses the synchronizer only.

Test Plan:
- Mode 0, MSB first, tx_data=0xA5 loaded, master sends 0x3C at clk/8 → MISO bit sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; SPIF=1; tx_ready=1 after SS falls.
- Mode 3, LSBFE=1, tx=0x01, master sends 0x80 → first MISO bit 1 then seven 0s; rx_data=0x80.
- Two back-to-back frames, 0x11 then 0x22, without SPIF_clr → rx_data=0x11; SPIF=1; rx_ovr=1 after the second frame. SPIF_clr then clears both flags.
- SS raised after 5 bits of 0xFF → SPIF stays 0, rx_data unchanged, MISO_oe=0. The next full frame of 0x5A gives rx_data=0x5A.
- tx_load while tx_ready=0 (first 0x77, then 0x88) → the transmitted frame is 0x77; 0x88 is ignored.
- rst pulse mid-frame (after 3 bits) → all outputs return to reset values the next cycle; the following full frame of 0xC3 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave engine: default sizes, FSM state and
// the {CPOL, CPHA} mode encoding.
package spi_pkg;

    localparam int unsigned DATA_W_DEFAULT      = 8;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    typedef enum logic [1:0] {
        Mode0 = 2'b00,
        Mode1 = 2'b01,
        Mode2 = 2'b10,
        Mode3 = 2'b11
    } spi_mode_e;

    function automatic logic mode_cpol(input spi_mode_e m);
        logic [1:0] b;
        b = m;
        return b[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_e m);
        logic [1:0] b;
        b = m;
        return b[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with single-cycle rise/fall
// pulses derived from the synchronized level and its delayed copy.
module spi_sync_edge #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[Stages-2:0], d_i};
        prev_d = sync_q[Stages-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {Stages{rst_val_i}};
            prev_q <= rst_val_i;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q[Stages-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI slave engine: oversamples SCK/SS/MOSI in the clk domain, shifts full-duplex
// frames, and offers a one-deep tx buffer plus an rx register with SPIF/overrun.
module spi_slave_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPE,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              LSBFE,
    input  logic              SCK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              SPIF,
    input  logic              SPIF_clr,
    output logic              rx_ovr
);

    localparam int unsigned      CntW   = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntMax = CntW'(DATA_W - 1);

    function automatic logic first_bit(input logic lsb, input logic [DATA_W-1:0] v);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic lsb,
                                                    input logic [DATA_W-1:0] v);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic lsb,
                                                   input logic [DATA_W-1:0] v,
                                                   input logic b);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    logic       sck_sync, sck_rise, sck_fall;
    logic       ss_sync, ss_rise, ss_fall;
    logic       mosi_sync;
    logic [1:0] unused_mosi_edge;

    spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sck (
        .clk_i    (clk),
        .rst_i    (rst),
        .rst_val_i(CPOL),
        .d_i      (SCK),
        .q_o      (sck_sync),
        .rise_o   (sck_rise),
        .fall_o   (sck_fall)
    );

    spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_ss (
        .clk_i    (clk),
        .rst_i    (rst),
        .rst_val_i(1'b1),
        .d_i      (SS),
        .q_o      (ss_sync),
        .rise_o   (ss_rise),
        .fall_o   (ss_fall)
    );

    spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_mosi (
        .clk_i    (clk),
        .rst_i    (rst),
        .rst_val_i(1'b0),
        .d_i      (MOSI),
        .q_o      (mosi_sync),
        .rise_o   (unused_mosi_edge[0]),
        .fall_o   (unused_mosi_edge[1])
    );

    spi_mode_e mode;
    logic      cpol, cpha, sck_edge, lead, trail;

    assign mode     = spi_mode_e'({CPOL, CPHA});
    assign cpol     = mode_cpol(mode);
    assign cpha     = mode_cpha(mode);
    assign sck_edge = sck_rise | sck_fall;
    // Leading edge moves SCK away from its idle level, trailing edge returns it.
    assign lead     = sck_edge & (sck_sync ^ cpol);
    assign trail    = sck_edge & ~(sck_sync ^ cpol);

    state_e state_q, state_d;
    logic   start, abort;

    assign start = (state_q == StIdle) & SPE & ss_fall;
    assign abort = ~SPE | ss_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StActive;
            StActive: if (abort) state_d = StIdle;
        endcase
    end

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
    logic              fresh_q, fresh_d, miso_q, miso_d, oe_q, oe_d;
    logic              tx_full_q, tx_full_d, spif_q, spif_d, ovr_q, ovr_d;

    logic              active, sample, shift, reload, take, accept, complete;
    logic [DATA_W-1:0] frame_src, rx_next;

    always_comb begin
        active    = (state_q == StActive) & ~abort;
        sample    = active & (cpha ? trail : lead);
        shift     = active & (cpha ? lead : trail);
        // A wrapped counter at a shift point without a fresh load starts the next frame.
        reload    = shift & (cnt_q == '0) & ~fresh_q;
        take      = tx_full_q & (start | reload);
        accept    = tx_load & (~tx_full_q | take);
        frame_src = tx_full_q ? tx_buf_q : '0;
        rx_next   = shift_in(LSBFE, rx_sr_q, mosi_sync);
        complete  = sample & (cnt_q == CntMax);

        cnt_d     = cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        fresh_d   = fresh_q;
        miso_d    = miso_q;
        oe_d      = SPE & ~ss_sync;
        tx_buf_d  = accept ? tx_data : tx_buf_q;
        tx_full_d = accept | (tx_full_q & ~take);

        if (start) begin
            cnt_d = '0;
            if (cpha) begin
                tx_sr_d = frame_src;
                fresh_d = 1'b1;
                miso_d  = 1'b0;
            end else begin
                tx_sr_d = shift_out(LSBFE, frame_src);
                fresh_d = 1'b0;
                miso_d  = first_bit(LSBFE, frame_src);
            end
        end else if ((state_q == StActive) && abort) begin
            cnt_d   = '0;
            fresh_d = 1'b0;
            miso_d  = 1'b0;
        end else if (active) begin
            if (shift) begin
                fresh_d = 1'b0;
                if (reload) begin
                    miso_d  = first_bit(LSBFE, frame_src);
                    tx_sr_d = shift_out(LSBFE, frame_src);
                end else begin
                    miso_d  = first_bit(LSBFE, tx_sr_q);
                    tx_sr_d = shift_out(LSBFE, tx_sr_q);
                end
            end
            if (sample) begin
                rx_sr_d = rx_next;
                cnt_d   = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
            end
        end

        // A completing frame overrides a simultaneous clear.
        rx_data_d = rx_data_q;
        spif_d    = spif_q & ~SPIF_clr;
        ovr_d     = ovr_q & ~SPIF_clr;
        if (complete) begin
            if (!spif_d) begin
                rx_data_d = rx_next;
                spif_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            fresh_q   <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            tx_buf_q  <= '0;
            tx_full_q <= 1'b0;
            rx_data_q <= '0;
            spif_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            fresh_q   <= fresh_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            tx_buf_q  <= tx_buf_d;
            tx_full_q <= tx_full_d;
            rx_data_q <= rx_data_d;
            spif_q    <= spif_d;
            ovr_q     <= ovr_d;
        end
    end

    assign MISO     = miso_q;
    assign MISO_oe  = oe_q;
    assign tx_ready = ~tx_full_q;
    assign rx_data  = rx_data_q;
    assign SPIF     = spif_q;
    assign rx_ovr   = ovr_q;

endmodule
